pc_fetch: RTL and testbench

Program-counter register and instruction-fetch sequencer for the single-cycle core. It holds the current PC, drives it to the PC+4 adder and to instruction memory through a req/ack handshake, and presents the fetched instruction to decode. It then commits the next PC, selecting among PC+4 (returned by the adder), branch target and jump target. It sits directly upstream of the PC+4 adder and consumes that adder's output.

---
 rtl/pc_fetch_pkg.sv | 14 +
 rtl/pc_next_sel.sv | 25 ++
 rtl/pc_fetch.sv | 113 +++++++++++
 tb/tb_pc_fetch.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch sequencer.
package pc_fetch_pkg;

   localparam int unsigned PC_W = 32;
   localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      EXEC = 2'd2,
      HALT = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux (jump > branch > pc+4) with word-alignment check.
module pc_next_sel
   import pc_fetch_pkg::*;
(
   input  logic            jump_taken,
   input  logic [PC_W-1:0] jump_target,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   input  logic [PC_W-1:0] pc_plus4,
   output logic [PC_W-1:0] next_pc,
   output logic            misaligned
);

   // Select the successor PC and flag a target that is not word-aligned.
   always_comb begin
      next_pc = pc_plus4;
      if (jump_taken) begin
         next_pc = jump_target;
      end else if (branch_taken) begin
         next_pc = branch_target;
      end
      misaligned = |next_pc[1:0];
   end

endmodule

// File: rtl/pc_fetch.sv
// Program-counter register and instruction-fetch sequencer.
// Optional feature: PC_FETCH_MISALIGN_TRAP_EN -- a misaligned next PC at
// commit halts the sequencer and sets the sticky misalign_err flag instead
// of being silently word-aligned.
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_plus4,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump_taken,
   input  logic [31:0] jump_target,
   input  logic        stall,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] instr_out,
   output logic        instr_valid,
   output logic        misalign_err
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [31:0]     instr_q, instr_d;
   logic            misalign_q, misalign_d;

   logic [PC_W-1:0] sel_pc;
   logic            sel_misaligned;

   pc_next_sel u_next_sel (
      .jump_taken    (jump_taken),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .pc_plus4      (pc_plus4),
      .next_pc       (sel_pc),
      .misaligned    (sel_misaligned)
   );

`ifndef PC_FETCH_MISALIGN_TRAP_EN
   // Low PC bits and the misalign indication are discarded when aligning.
   logic [2:0] unused_sel_bits;
   assign unused_sel_bits = {sel_misaligned, sel_pc[1:0]};
`endif

   // Next-state, PC commit and instruction capture.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      misalign_d = misalign_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (!stall) begin
`ifdef PC_FETCH_MISALIGN_TRAP_EN
               if (sel_misaligned) begin
                  misalign_d = 1'b1;
                  state_d    = HALT;
               end else begin
                  pc_d    = sel_pc;
                  state_d = REQ;
               end
`else
               pc_d    = {sel_pc[PC_W-1:2], 2'b00};
               state_d = REQ;
`endif
            end
         end
         HALT: state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset clears everything immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= RESET_VECTOR;
         instr_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         misalign_q <= misalign_d;
      end
   end

   // Outputs decoded from the registered state, so reset drops imem_req at once.
   always_comb begin
      pc_out       = pc_q;
      imem_addr    = pc_q;
      imem_req     = (state_q == REQ);
      instr_valid  = (state_q == EXEC);
      instr_out    = instr_q;
      misalign_err = misalign_q;
   end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed testbench for pc_fetch; the PC+4 adder is modelled here.
module tb_pc_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_plus4;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump_taken;
   logic [31:0] jump_target;
   logic        stall;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic        misalign_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign pc_plus4 = pc_out + 32'd4;

   pc_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clk           (clk),
      .reset         (reset),
      .pc_plus4      (pc_plus4),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump_taken    (jump_taken),
      .jump_target   (jump_target),
      .stall         (stall),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .pc_out        (pc_out),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .instr_out     (instr_out),
      .instr_valid   (instr_valid),
      .misalign_err  (misalign_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge while in REQ: ack this cycle with the given word.
   task automatic fetch(input logic [31:0] data);
      imem_ack   = 1'b1;
      imem_rdata = data;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
   endtask

   // Called at a negedge while in EXEC: commit with the given decision.
   task automatic commit(input logic jt, input logic [31:0] jtgt,
                         input logic bt, input logic [31:0] btgt);
      jump_taken    = jt;
      jump_target   = jtgt;
      branch_taken  = bt;
      branch_target = btgt;
      @(negedge clk);
      jump_taken    = 1'b0;
      branch_taken  = 1'b0;
   endtask

   initial begin
      reset = 1'b1; branch_taken = 1'b0; branch_target = '0;
      jump_taken = 1'b0; jump_target = '0; stall = 1'b0;
      imem_ack = 1'b0; imem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_instr", instr_out, 32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'h0);
      chk("rst_mis", {31'b0, misalign_err}, 32'h0);

      // First fetch, ack in the first REQ cycle
      reset = 1'b0;
      @(negedge clk);
      chk("f0_req", {31'b0, imem_req}, 32'h1);
      chk("f0_addr", imem_addr, 32'h0);
      fetch(32'h0000_0013);
      chk("f0_valid", {31'b0, instr_valid}, 32'h1);
      chk("f0_instr", instr_out, 32'h13);
      chk("f0_req_exec", {31'b0, imem_req}, 32'h0);
      commit(1'b0, '0, 1'b0, '0);
      chk("f0_valid_drop", {31'b0, instr_valid}, 32'h0);
      chk("f0_pc4", pc_out, 32'h4);
      chk("f1_addr", imem_addr, 32'h4);

      fetch(32'h0000_0001);
      commit(1'b0, '0, 1'b0, '0);
      chk("f1_pc8", pc_out, 32'h8);

      // Delayed ack: three wait cycles at 0x8
      for (int i = 0; i < 3; i++) begin
         chk("wait_addr", imem_addr, 32'h8);
         chk("wait_req", {31'b0, imem_req}, 32'h1);
         chk("wait_valid", {31'b0, instr_valid}, 32'h0);
         @(negedge clk);
      end
      fetch(32'h0000_0002);
      chk("wait_done_valid", {31'b0, instr_valid}, 32'h1);
      chk("wait_done_instr", instr_out, 32'h2);

      // Jump beats branch
      commit(1'b1, 32'h100, 1'b1, 32'h40);
      chk("jmp_wins", pc_out, 32'h100);
      fetch(32'h0000_0003);
      commit(1'b0, 32'h100, 1'b1, 32'h40);
      chk("br_only", pc_out, 32'h40);

      // Stall two EXEC cycles; ack/decision while stalled must be ignored
      fetch(32'h0000_ABCD);
      stall = 1'b1;
      imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
      jump_taken = 1'b1; jump_target = 32'h200;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("stall_pc", pc_out, 32'h40);
         chk("stall_instr", instr_out, 32'h0000_ABCD);
         chk("stall_valid", {31'b0, instr_valid}, 32'h1);
      end
      imem_ack = 1'b0; jump_taken = 1'b0; stall = 1'b0;
      commit(1'b0, '0, 1'b0, '0);
      chk("stall_adv", pc_out, 32'h44);

      // Wrap of PC+4 at the top of the address space
      fetch(32'h0000_0004);
      commit(1'b1, 32'hFFFF_FFFC, 1'b0, '0);
      chk("top_pc", pc_out, 32'hFFFF_FFFC);
      fetch(32'h0000_0005);
      commit(1'b0, '0, 1'b0, '0);
      chk("wrap_pc", pc_out, 32'h0);
      chk("wrap_mis", {31'b0, misalign_err}, 32'h0);

      // Misaligned jump target
      fetch(32'h0000_0006);
      commit(1'b1, 32'h102, 1'b0, '0);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      chk("mis_pc_hold", pc_out, 32'h0);
      chk("mis_flag", {31'b0, misalign_err}, 32'h1);
      chk("mis_valid", {31'b0, instr_valid}, 32'h0);
      imem_ack = 1'b1;
      repeat (3) @(negedge clk);
      imem_ack = 1'b0;
      chk("halt_req", {31'b0, imem_req}, 32'h0);
      chk("halt_valid", {31'b0, instr_valid}, 32'h0);
      chk("halt_flag", {31'b0, misalign_err}, 32'h1);
`else
      chk("mis_aligned_pc", pc_out, 32'h100);
      chk("mis_flag0", {31'b0, misalign_err}, 32'h0);
      chk("mis_req", {31'b0, imem_req}, 32'h1);
`endif

      // Restart, then reset asynchronously in REQ at 0x20
      reset = 1'b1;
      @(negedge clk);
      chk("rst2_mis", {31'b0, misalign_err}, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      fetch(32'h0000_0007);
      commit(1'b1, 32'h20, 1'b0, '0);
      chk("r_addr20", imem_addr, 32'h20);
      chk("r_req20", {31'b0, imem_req}, 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("async_req", {31'b0, imem_req}, 32'h0);
      chk("async_pc", pc_out, 32'h0);
      chk("async_valid", {31'b0, instr_valid}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("restart_req", {31'b0, imem_req}, 32'h1);
      chk("restart_addr", imem_addr, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
